// File: rtl/tube_if.sv
// Tube host/parasite bus bundle.
// master = bus side (host CPU, parasite CPU, DMA), slave = ULA.
interface tube_if;
   logic HCS, HRW, HA2, HA1, HA0;
   logic HD7IN, HD6IN, HD5IN, HD4IN;
   logic HD3IN, HD2IN, HD1IN, HD0IN;
   logic HD7OUT, HD6OUT, HD5OUT, HD4OUT;
   logic HD3OUT, HD2OUT, HD1OUT, HD0OUT;
   logic HDOE, HIRQ;
   logic PCS, PNRDS, PNWDS, PA2, PA1, PA0;
   logic PD7IN, PD6IN, PD5IN, PD4IN;
   logic PD3IN, PD2IN, PD1IN, PD0IN;
   logic PD7OUT, PD6OUT, PD5OUT, PD4OUT;
   logic PD3OUT, PD2OUT, PD1OUT, PD0OUT;
   logic PDOE, PIRQ, PNMI, PRST, DRQ, DACK;

   modport master (
      output HCS, HRW, HA2, HA1, HA0,
      output HD7IN, HD6IN, HD5IN, HD4IN,
      output HD3IN, HD2IN, HD1IN, HD0IN,
      input  HD7OUT, HD6OUT, HD5OUT, HD4OUT,
      input  HD3OUT, HD2OUT, HD1OUT, HD0OUT,
      input  HDOE, HIRQ,
      output PCS, PNRDS, PNWDS, PA2, PA1, PA0,
      output PD7IN, PD6IN, PD5IN, PD4IN,
      output PD3IN, PD2IN, PD1IN, PD0IN,
      input  PD7OUT, PD6OUT, PD5OUT, PD4OUT,
      input  PD3OUT, PD2OUT, PD1OUT, PD0OUT,
      input  PDOE, PIRQ, PNMI, PRST, DRQ,
      output DACK
   );

   modport slave (
      input  HCS, HRW, HA2, HA1, HA0,
      input  HD7IN, HD6IN, HD5IN, HD4IN,
      input  HD3IN, HD2IN, HD1IN, HD0IN,
      output HD7OUT, HD6OUT, HD5OUT, HD4OUT,
      output HD3OUT, HD2OUT, HD1OUT, HD0OUT,
      output HDOE, HIRQ,
      input  PCS, PNRDS, PNWDS, PA2, PA1, PA0,
      input  PD7IN, PD6IN, PD5IN, PD4IN,
      input  PD3IN, PD2IN, PD1IN, PD0IN,
      output PD7OUT, PD6OUT, PD5OUT, PD4OUT,
      output PD3OUT, PD2OUT, PD1OUT, PD0OUT,
      output PDOE, PIRQ, PNMI, PRST, DRQ,
      input  DACK
   );
endinterface

// File: rtl/tube_ula.sv
// Tube ULA: four mailbox pairs between a 6502 host and a parasite CPU.
// Mailbox index: 0..3 host->parasite R1..R4, 4..7 parasite->host R1..R4.
module tube_ula (
   input logic   HO2,
   input logic   HRST,
   tube_if.slave bus
);
   logic [7:0] hdin, pdin, hout, pout;
   logic [2:0] ha, pa;
   logic       psel, hwr, ctl, flush;

   assign hdin = ~{bus.HD7IN, bus.HD6IN, bus.HD5IN, bus.HD4IN,
                   bus.HD3IN, bus.HD2IN, bus.HD1IN, bus.HD0IN};
   assign pdin = {bus.PD7IN, bus.PD6IN, bus.PD5IN, bus.PD4IN,
                  bus.PD3IN, bus.PD2IN, bus.PD1IN, bus.PD0IN};
   assign ha   = {bus.HA2, bus.HA1, bus.HA0};
   assign psel = bus.PCS | bus.DACK;
   assign pa   = bus.DACK ? 3'd5 : {bus.PA2, bus.PA1, bus.PA0};

   // flags: 0 Q, 1 I, 2 J, 3 M, 4 V, 5 P
   logic [5:0] flg;
   logic [1:0] cnt [8];
   logic [7:0] hd [8];
   logic [7:0] tl [8];

   logic       hrdq, prdq, pwrq;
   logic [1:0] hraq, praq, pwaq;
   logic [7:0] pwd;

   logic [7:0] push, pop, dpush, dpop, av, nf;
   logic [1:0] cap [8];
   logic [1:0] lvl [8];

   assign hwr   = ~bus.HCS & ~bus.HRW;
   assign ctl   = hwr & (ha == 3'd0);
   assign flush = ctl & hdin[7] & hdin[6];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < 4; i++) begin
         push[i]   = hwr & ha[0] & (ha[2:1] == 2'(i));
         push[4+i] = pwrq & bus.PNWDS & (pwaq == 2'(i));
         pop[i]    = prdq & bus.PNRDS & (praq == 2'(i));
         pop[4+i]  = hrdq & bus.HCS & (hraq == 2'(i));
      end
      for (int i = 0; i < 8; i++) begin
         cap[i]   = ((i == 2 || i == 6) && flg[4]) ? 2'd2 : 2'd1;
         dpop[i]  = pop[i] & (cnt[i] != 2'd0);
         lvl[i]   = cnt[i] - {1'b0, dpop[i]};
         dpush[i] = push[i] & (lvl[i] < cap[i]);
         av[i]    = cnt[i] != 2'd0;
         nf[i]    = cnt[i] < cap[i];
      end
   end

   always_ff @(posedge HO2 or negedge HRST) begin
      if (!HRST) begin
         flg  <= '0;
         hrdq <= 1'b0;
         prdq <= 1'b0;
         pwrq <= 1'b0;
         hraq <= '0;
         praq <= '0;
         pwaq <= '0;
         pwd  <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
            hd[i]  <= '0;
            tl[i]  <= '0;
         end
      end else begin
         hrdq <= ~bus.HCS & bus.HRW & ha[0];
         hraq <= ha[2:1];
         prdq <= psel & ~bus.PNRDS & pa[0];
         praq <= pa[2:1];
         pwrq <= psel & ~bus.PNWDS & pa[0];
         pwaq <= pa[2:1];
         if (psel & ~bus.PNWDS)
            pwd <= pdin;
         if (ctl) begin
            if (hdin[7]) flg <= flg | hdin[5:0];
            else         flg <= flg & ~hdin[5:0];
         end
         for (int i = 0; i < 8; i++) begin
            if (dpop[i] && cnt[i] == 2'd2)
               hd[i] <= tl[i];
            if (dpush[i]) begin
               if (lvl[i] == 2'd0) hd[i] <= (i < 4) ? hdin : pwd;
               else                tl[i] <= (i < 4) ? hdin : pwd;
            end
            if (flush) cnt[i] <= '0;
            else       cnt[i] <= lvl[i] + {1'b0, dpush[i]};
         end
      end
   end

   always_comb begin
      hout = {av[{1'b1, ha[2:1]}], nf[{1'b0, ha[2:1]}],
              (ha == 3'd0) ? flg : 6'd0};
      if (ha[0]) hout = hd[{1'b1, ha[2:1]}];
      pout = {av[{1'b0, pa[2:1]}], nf[{1'b1, pa[2:1]}],
              (pa == 3'd0) ? flg : 6'd0};
      if (pa[0]) pout = hd[{1'b0, pa[2:1]}];
   end

   assign {bus.HD7OUT, bus.HD6OUT, bus.HD5OUT, bus.HD4OUT,
           bus.HD3OUT, bus.HD2OUT, bus.HD1OUT, bus.HD0OUT} = hout;
   assign {bus.PD7OUT, bus.PD6OUT, bus.PD5OUT, bus.PD4OUT,
           bus.PD3OUT, bus.PD2OUT, bus.PD1OUT, bus.PD0OUT} = pout;

   assign bus.HDOE = ~bus.HCS & bus.HRW;
   assign bus.PDOE = psel & ~bus.PNRDS;
   assign bus.HIRQ = ~(flg[0] & av[7]);
   assign bus.PIRQ = ~((flg[1] & av[0]) | (flg[2] & av[3]));
   assign bus.PNMI = ~(flg[3] & (av[2] | nf[6]));
   assign bus.PRST = HRST & ~flg[5];
   assign bus.DRQ  = flg[3] & flg[4] & (cnt[2] == 2'd2) & ~bus.DACK;
endmodule

// File: tb/tb_tube_ula.sv
// Testbench for tube_ula: vector table plus hand-written corner sequences,
// all checks routed through an expected-value scoreboard queue.
module tb_tube_ula;
   logic clk, rst;
   tube_if u_if ();

   tube_ula dut (.HO2(clk), .HRST(rst), .bus(u_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {OP_HW, OP_HR, OP_PW, OP_PR, OP_DR} op_e;
   typedef struct {
      op_e        op;
      logic [2:0] a;
      logic [7:0] d;
      bit         ck;
      logic [4:0] o;
      string      nm;
   } vec_t;
   typedef struct {
      string      nm;
      logic [7:0] exp;
   } sb_t;

   vec_t vq[$];
   sb_t  sb[$];
   int   npass = 0;
   int   ntot = 0;

   logic [7:0] hq, pq;
   logic [4:0] oq;
   assign hq = {u_if.HD7OUT, u_if.HD6OUT, u_if.HD5OUT, u_if.HD4OUT,
                u_if.HD3OUT, u_if.HD2OUT, u_if.HD1OUT, u_if.HD0OUT};
   assign pq = {u_if.PD7OUT, u_if.PD6OUT, u_if.PD5OUT, u_if.PD4OUT,
                u_if.PD3OUT, u_if.PD2OUT, u_if.PD1OUT, u_if.PD0OUT};
   assign oq = {u_if.HIRQ, u_if.PIRQ, u_if.PNMI, u_if.PRST, u_if.DRQ};

   task automatic expect8(input string nm, input logic [7:0] e);
      sb.push_back('{nm, e});
   endtask

   task automatic sb_chk(input logic [7:0] act);
      sb_t e;
      ntot++;
      if (sb.size() == 0) begin
         $display("FAIL sb_empty: got %02h want none", act);
         return;
      end
      e = sb.pop_front();
      if (act !== e.exp)
         $display("FAIL %s: got %02h want %02h", e.nm, act, e.exp);
      else
         npass++;
   endtask

   task automatic set_h(input logic [2:0] a, input logic [7:0] d);
      {u_if.HA2, u_if.HA1, u_if.HA0} = a;
      {u_if.HD7IN, u_if.HD6IN, u_if.HD5IN, u_if.HD4IN,
       u_if.HD3IN, u_if.HD2IN, u_if.HD1IN, u_if.HD0IN} = ~d;
   endtask

   task automatic set_p(input logic [2:0] a, input logic [7:0] d);
      {u_if.PA2, u_if.PA1, u_if.PA0} = a;
      {u_if.PD7IN, u_if.PD6IN, u_if.PD5IN, u_if.PD4IN,
       u_if.PD3IN, u_if.PD2IN, u_if.PD1IN, u_if.PD0IN} = d;
   endtask

   task automatic hw(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      set_h(a, d);
      u_if.HCS = 1'b0;
      u_if.HRW = 1'b0;
      @(negedge clk);
      u_if.HCS = 1'b1;
      u_if.HRW = 1'b1;
   endtask

   task automatic hr(input logic [2:0] a, input logic [7:0] e,
                     input string nm);
      @(negedge clk);
      set_h(a, 8'h00);
      u_if.HCS = 1'b0;
      u_if.HRW = 1'b1;
      expect8(nm, e);
      #1 sb_chk(hq);
      @(negedge clk);
      u_if.HCS = 1'b1;
      @(negedge clk);
   endtask

   task automatic pw(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      set_p(a, d);
      u_if.PCS   = 1'b1;
      u_if.PNWDS = 1'b0;
      @(negedge clk);
      u_if.PNWDS = 1'b1;
      u_if.PCS   = 1'b0;
      @(negedge clk);
   endtask

   task automatic pr(input logic [2:0] a, input bit dack,
                     input logic [7:0] e, input string nm);
      @(negedge clk);
      set_p(a, 8'h00);
      u_if.PCS   = ~dack;
      u_if.DACK  = dack;
      u_if.PNRDS = 1'b0;
      expect8(nm, e);
      #1 sb_chk(pq);
      @(negedge clk);
      u_if.PNRDS = 1'b1;
      u_if.PCS   = 1'b0;
      u_if.DACK  = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_o(input string nm, input logic [4:0] e);
      expect8(nm, {3'b000, e});
      #1 sb_chk({3'b000, oq});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      u_if.HCS = 1'b1; u_if.HRW = 1'b1;
      u_if.PCS = 1'b0; u_if.PNRDS = 1'b1;
      u_if.PNWDS = 1'b1; u_if.DACK = 1'b0;
      set_h(3'd0, 8'h00);
      set_p(3'd0, 8'h00);

      for (int i = 0; i < 8; i++) begin
         vq.push_back('{OP_HR, 3'(i), i[0] ? 8'h00 : 8'h40,
                        1'b0, 5'b0, "rst_h"});
         vq.push_back('{OP_PR, 3'(i), i[0] ? 8'h00 : 8'h40,
                        1'b0, 5'b0, "rst_p"});
      end
      vq.push_back('{OP_HR, 3'd0, 8'h40, 1'b1, 5'b11110, "rst_out"});
      vq.push_back('{OP_HW, 3'd0, 8'hFF, 1'b1, 5'b11000, "ctl_ff"});
      vq.push_back('{OP_HR, 3'd0, 8'h7F, 1'b0, 5'b0, "flags_h"});
      vq.push_back('{OP_PR, 3'd0, 8'h7F, 1'b0, 5'b0, "flags_p"});
      vq.push_back('{OP_HW, 3'd0, 8'hAA, 1'b0, 5'b0, "ctl_aa"});
      vq.push_back('{OP_HR, 3'd0, 8'h7F, 1'b0, 5'b0, "flags_aa"});
      vq.push_back('{OP_HW, 3'd0, 8'h20, 1'b1, 5'b11010, "clr_p"});
      vq.push_back('{OP_HR, 3'd0, 8'h5F, 1'b0, 5'b0, "flags_1f"});
      vq.push_back('{OP_HW, 3'd1, 8'h5A, 1'b1, 5'b10010, "r1_pirq"});
      vq.push_back('{OP_PR, 3'd0, 8'hDF, 1'b0, 5'b0, "r1_pst"});
      vq.push_back('{OP_HR, 3'd0, 8'h1F, 1'b0, 5'b0, "r1_hst"});
      vq.push_back('{OP_PR, 3'd1, 8'h5A, 1'b1, 5'b11010, "r1_data"});
      vq.push_back('{OP_PR, 3'd0, 8'h5F, 1'b0, 5'b0, "r1_empty"});
      vq.push_back('{OP_PW, 3'd5, 8'h11, 1'b0, 5'b0, "r3_w1"});
      vq.push_back('{OP_PW, 3'd5, 8'h22, 1'b1, 5'b11110, "r3_full"});
      vq.push_back('{OP_HR, 3'd4, 8'hC0, 1'b0, 5'b0, "r3_hst"});
      vq.push_back('{OP_PR, 3'd4, 8'h00, 1'b0, 5'b0, "r3_pst"});
      vq.push_back('{OP_PW, 3'd5, 8'h33, 1'b0, 5'b0, "r3_w3"});
      vq.push_back('{OP_HR, 3'd5, 8'h11, 1'b0, 5'b0, "r3_rd1"});
      vq.push_back('{OP_HR, 3'd5, 8'h22, 1'b1, 5'b11010, "r3_rd2"});
      vq.push_back('{OP_HR, 3'd5, 8'h22, 1'b0, 5'b0, "r3_empty"});
      vq.push_back('{OP_HR, 3'd4, 8'h40, 1'b0, 5'b0, "r3_hst0"});
      vq.push_back('{OP_PW, 3'd7, 8'h77, 1'b1, 5'b01010, "r4_hirq"});
      vq.push_back('{OP_HR, 3'd7, 8'h77, 1'b1, 5'b11010, "r4_data"});
      vq.push_back('{OP_HW, 3'd1, 8'h33, 1'b0, 5'b0, "pre_t_h"});
      vq.push_back('{OP_PW, 3'd1, 8'h44, 1'b0, 5'b0, "pre_t_p"});
      vq.push_back('{OP_HW, 3'd0, 8'hC0, 1'b1, 5'b11010, "flush"});
      vq.push_back('{OP_HR, 3'd0, 8'h5F, 1'b0, 5'b0, "flush_h"});
      vq.push_back('{OP_PR, 3'd0, 8'h5F, 1'b0, 5'b0, "flush_p"});
      vq.push_back('{OP_HW, 3'd5, 8'h01, 1'b1, 5'b11010, "dma_w1"});
      vq.push_back('{OP_HW, 3'd5, 8'h02, 1'b1, 5'b11011, "drq"});
      vq.push_back('{OP_DR, 3'd0, 8'h01, 1'b1, 5'b11010, "dack"});
      vq.push_back('{OP_HW, 3'd0, 8'h10, 1'b0, 5'b0, "clr_v"});
      vq.push_back('{OP_PR, 3'd4, 8'hC0, 1'b0, 5'b0, "v0_pst"});
      vq.push_back('{OP_PW, 3'd5, 8'h55, 1'b0, 5'b0, "v0_w1"});
      vq.push_back('{OP_PW, 3'd5, 8'h66, 1'b0, 5'b0, "v0_w2"});
      vq.push_back('{OP_HR, 3'd5, 8'h55, 1'b0, 5'b0, "v0_rd"});
      vq.push_back('{OP_HR, 3'd5, 8'h55, 1'b0, 5'b0, "v0_empty"});
      vq.push_back('{OP_HW, 3'd0, 8'h90, 1'b0, 5'b0, "set_v"});
      vq.push_back('{OP_PW, 3'd5, 8'hA1, 1'b0, 5'b0, "lo_w1"});
      vq.push_back('{OP_PW, 3'd5, 8'hA2, 1'b0, 5'b0, "lo_w2"});
      vq.push_back('{OP_HW, 3'd0, 8'h10, 1'b0, 5'b0, "clr_v2"});
      vq.push_back('{OP_PR, 3'd4, 8'h80, 1'b0, 5'b0, "lo_pst"});
      vq.push_back('{OP_HR, 3'd5, 8'hA1, 1'b0, 5'b0, "lo_rd1"});
      vq.push_back('{OP_HR, 3'd5, 8'hA2, 1'b0, 5'b0, "lo_rd2"});

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_o("in_rst", 5'b11100);
      repeat (7) @(negedge clk);
      rst = 1'b1;

      foreach (vq[k]) begin
         case (vq[k].op)
            OP_HW: hw(vq[k].a, vq[k].d);
            OP_HR: hr(vq[k].a, vq[k].d, vq[k].nm);
            OP_PW: pw(vq[k].a, vq[k].d);
            OP_PR: pr(vq[k].a, 1'b0, vq[k].d, vq[k].nm);
            OP_DR: pr(vq[k].a, 1'b1, vq[k].d, vq[k].nm);
            default: ;
         endcase
         if (vq[k].ck)
            chk_o({vq[k].nm, "_o"}, vq[k].o);
      end

      // push and pop on a full R1 in the same cycle keeps the new byte
      hw(3'd1, 8'hAB);
      @(negedge clk);
      set_p(3'd1, 8'h00);
      u_if.PCS = 1'b1;
      u_if.PNRDS = 1'b0;
      expect8("sim_old", 8'hAB);
      #1 sb_chk(pq);
      @(negedge clk);
      u_if.PNRDS = 1'b1;
      u_if.PCS = 1'b0;
      set_h(3'd1, 8'hCD);
      u_if.HCS = 1'b0;
      u_if.HRW = 1'b0;
      @(negedge clk);
      u_if.HCS = 1'b1;
      u_if.HRW = 1'b1;
      pr(3'd0, 1'b0, 8'hCF, "sim_pst");
      pr(3'd1, 1'b0, 8'hCD, "sim_new");
      pr(3'd0, 1'b0, 8'h4F, "sim_drain");

      // reset in the middle of a parasite write leaves R4 empty
      @(negedge clk);
      set_p(3'd7, 8'hEE);
      u_if.PCS = 1'b1;
      u_if.PNWDS = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      chk_o("mid_rst", 5'b11100);
      @(negedge clk);
      u_if.PNWDS = 1'b1;
      u_if.PCS = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      hr(3'd6, 8'h40, "abort_st");
      hr(3'd7, 8'h00, "abort_dat");
      chk_o("abort_o", 5'b11110);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
